ram_row_reader: RTL and testbench

RAM_ROW_READER -- requirements
Module: ram_row_reader

---
 rtl/ram_row_reader.sv | 95 +++++++++
 tb/tb_ram_row_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ram_row_reader.sv
// ram_row_reader: streams num_rows strided RAM rows through a 2-entry buffer to a valid/ready consumer.
// The first row bypasses the empty buffer so it appears two cycles after start.
module ram_row_reader #(
    parameter int AWIDTH      = 10,
    parameter int DESIGN_SIZE = 16,
    parameter int DWIDTH      = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [AWIDTH-1:0]             base_addr,
    input  logic [AWIDTH-1:0]             num_rows,
    input  logic [AWIDTH-1:0]             stride,
    output logic                          busy,
    output logic                          done,
    output logic [AWIDTH-1:0]             ram_addr,
    output logic [DESIGN_SIZE-1:0]        ram_we,
    output logic [DESIGN_SIZE*DWIDTH-1:0] ram_d,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] ram_q,
    output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last
);
    localparam int RW = DESIGN_SIZE * DWIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t            state, state_nx;
    logic [AWIDTH-1:0] rows_r, stride_r, icnt, acnt, addr_r;
    logic              pend, rd_ptr, wr_ptr, issue, last_issue, pop, push, fifo_rd;
    logic [1:0]        cnt;
    logic [RW-1:0]     fifo [2];

    // pend marks a read whose row appears on ram_q this cycle
    assign issue      = state == ISSUE && ({1'b0, pend} + cnt) < 2'd2;
    assign last_issue = icnt == rows_r - 1'b1;
    assign out_valid  = cnt != 2'd0 || pend;
    assign out_data   = cnt != 2'd0 ? fifo[rd_ptr] : pend ? ram_q : '0;
    assign out_last   = out_valid && acnt == rows_r - 1'b1;
    assign pop        = out_valid && out_ready;
    assign fifo_rd    = pop && cnt != 2'd0;
    assign push       = pend && !(pop && cnt == 2'd0);
    assign busy       = state != IDLE;
    assign done       = state == FIN;
    assign ram_addr   = addr_r;
    assign ram_we     = '0;
    assign ram_d      = '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = num_rows == '0 ? FIN : ISSUE;
            ISSUE:   if (issue && last_issue) state_nx = DRAIN;
            DRAIN:   if (pop && out_last) state_nx = FIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            rows_r   <= '0;
            stride_r <= '0;
            icnt     <= '0;
            acnt     <= '0;
            addr_r   <= '0;
            pend     <= 1'b0;
            cnt      <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            state <= state_nx;
            pend  <= issue;
            if (state == IDLE && start) begin
                rows_r   <= num_rows;
                stride_r <= stride;
                icnt     <= '0;
                acnt     <= '0;
                if (num_rows != '0) addr_r <= base_addr;
            end
            if (issue) begin
                icnt <= icnt + 1'b1;
                if (!last_issue) addr_r <= addr_r + stride_r;
            end
            if (pop) acnt <= acnt + 1'b1;
            if (push) wr_ptr <= ~wr_ptr;
            if (fifo_rd) rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, fifo_rd};
        end
    end

    always_ff @(posedge clk)
        if (push) fifo[wr_ptr] <= ram_q;
endmodule

// File: tb/tb_ram_row_reader.sv
// tb_ram_row_reader: directed checks of ram_row_reader against a registered RAM model and a row scoreboard.
module tb_ram_row_reader;
    localparam int AW = 10;
    localparam int RW = 128;

    logic          clk, resetn, start, out_ready;
    logic [AW-1:0] base_addr, num_rows, stride, ram_addr;
    logic          busy, done, out_valid, out_last;
    logic [15:0]   ram_we;
    logic [RW-1:0] ram_d, ram_q, out_data;

    int vectors = 0, miscompares = 0;
    int acc = 0, acc0 = 0, ndone = 0, nwr = 0;
    logic [AW-1:0] cur_base = '0, cur_stride = '0, cur_rows = '0;

    ram_row_reader dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .stride(stride), .busy(busy), .done(done),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    function automatic logic [RW-1:0] data_of(input logic [AW-1:0] a);
        logic [RW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = (a[7:0] + 8'(i * 29)) ^ {6'b0, a[9:8]};
        return r;
    endfunction

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    always @(posedge clk) ram_q <= data_of(ram_addr);

    // scoreboard: every presented row must be the next expected one, stable until taken
    always @(negedge clk) if (resetn) begin
        if (out_valid) begin
            if (acc - acc0 >= int'(cur_rows)) check("extra_row", 1, 0);
            else begin
                check("row_data", out_data, data_of(cur_base + AW'(acc - acc0) * cur_stride));
                check("row_last", out_last, (acc - acc0) == int'(cur_rows) - 1);
            end
            if (out_ready) acc++;
        end
        if (done) ndone++;
        if (ram_we != '0 || ram_d != '0) nwr++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [AW-1:0] n);
        base_addr = b; stride = s; num_rows = n;
        cur_base = b; cur_stride = s; cur_rows = n;
        acc0 = acc;
        start = 1;
        tick;
        start = 0;
    endtask

    task automatic wait_done;
        for (int i = 0; i < 200 && !done; i++) tick;
        check("done_seen", done, 1);
        tick;
    endtask

    initial begin
        int nd;
        logic [3:0] pat;
        pat = 4'b1001;
        resetn = 1; start = 0; out_ready = 1;
        base_addr = '0; num_rows = '0; stride = '0;
        #2 resetn = 0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_data", out_data, 0);
        tick; tick;
        resetn = 1;
        tick;

        // base 5, stride 1, 4 rows, consumer always ready
        nd = ndone;
        start_xfer(10'd5, 10'd1, 10'd4);
        check("t1_busy", busy, 1);
        check("t1_addr0", ram_addr, 5);
        check("t1_nvalid", out_valid, 0);
        for (int k = 1; k < 4; k++) begin
            tick;
            check("t1_addr", ram_addr, 5 + k);
            check("t1_valid", out_valid, 1);
        end
        tick;
        check("t1_valid4", out_valid, 1);
        check("t1_last4", out_last, 1);
        tick;
        check("t1_done", done, 1);
        check("t1_idle_valid", out_valid, 0);
        tick;
        check("t1_busy_end", busy, 0);
        check("t1_done_end", done, 0);
        check("t1_rows", acc - acc0, 4);
        check("t1_ndone", ndone - nd, 1);

        // address wrap modulo 1024
        start_xfer(10'd1020, 10'd3, 10'd3);
        check("t2_addr0", ram_addr, 1020);
        tick;
        check("t2_addr1", ram_addr, 1023);
        tick;
        check("t2_addr2", ram_addr, 2);
        wait_done;
        check("t2_rows", acc - acc0, 3);

        // 8 rows with a stalling consumer
        start_xfer(10'd100, 10'd2, 10'd8);
        for (int i = 0; i < 400 && !done; i++) begin
            out_ready = i < 4 ? pat[i] : 1'($urandom_range(0, 1));
            tick;
        end
        check("t3_done", done, 1);
        out_ready = 1;
        tick;
        check("t3_rows", acc - acc0, 8);
        check("t3_addr_hold", ram_addr, 114);

        // zero rows: no reads, no rows, a single done
        nd = ndone;
        start_xfer(10'd40, 10'd1, 10'd0);
        check("t4_done", done, 1);
        for (int i = 0; i < 4; i++) tick;
        check("t4_ndone", ndone - nd, 1);
        check("t4_busy", busy, 0);
        check("t4_rows", acc - acc0, 0);
        check("t4_addr", ram_addr, 114);

        // reset while row 3 of 10 is pending, then a fresh 2-row transfer
        start_xfer(10'd200, 10'd1, 10'd10);
        tick; tick; tick;
        resetn = 0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_valid", out_valid, 0);
        check("t5_last", out_last, 0);
        check("t5_done", done, 0);
        check("t5_addr", ram_addr, 0);
        check("t5_data", out_data, 0);
        tick;
        resetn = 1;
        tick;
        start_xfer(10'd50, 10'd5, 10'd2);
        wait_done;
        check("t5_rows", acc - acc0, 2);

        // restart attempts while busy are ignored
        start_xfer(10'd300, 10'd4, 10'd5);
        tick;
        base_addr = 10'd7; stride = 10'd9; num_rows = 10'd1;
        start = 1;
        tick; tick;
        start = 0;
        wait_done;
        check("t6_rows", acc - acc0, 5);
        check("t6_busy", busy, 0);
        check("no_writes", nwr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
